// File: rtl/note_lane_renderer.sv
// note_lane_renderer: 640x480 VGA raster with four scrolling note lanes, hit line and lane borders
module note_lane_renderer #(
   parameter int CLK_DIV = 4,
   parameter int BAR_H   = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [9:0]  offset_in,
   input  logic [3:0]  lane_mask,
   output logic        hsync,
   output logic        vsync,
   output logic [11:0] rgb,
   output logic        frame_tick
);

   localparam int          DW       = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
   localparam logic [9:0]  BAR      = 10'(BAR_H);
   localparam logic [47:0] LANE_RGB = {12'hFF0, 12'h00F, 12'h0F0, 12'hF00};

   logic [DW-1:0] div;
   logic          pix_en;
   logic          latch;
   logic          active;
   logic [9:0]    hcnt;
   logic [9:0]    vcnt;
   logic [9:0]    off_latched;
   logic [3:0]    mask_latched;
   logic [10:0]   ysum;
   logic [9:0]    ypos;
   logic [9:0]    lo;
   logic [9:0]    hi;
   logic [11:0]   pix_rgb;

   assign pix_en = div == DW'(CLK_DIV - 1);
   assign latch  = pix_en && hcnt == 10'd0 && vcnt == 10'd480;
   assign active = hcnt < 10'd640 && vcnt < 10'd480;
   assign ysum   = {1'b0, vcnt} + {1'b0, off_latched};
   assign ypos   = ysum >= 11'd480 ? 10'(ysum - 11'd480) : ysum[9:0];

   // pixel-rate divider: pix_en fires on the last count of each CLK_DIV window
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) div <= '0;
      else        div <= pix_en ? '0 : div + 1'b1;
   end

   // raster position: 800 pixels per line, 525 lines per frame
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hcnt <= '0;
         vcnt <= '0;
      end else if (pix_en) begin
         hcnt <= hcnt == 10'd799 ? 10'd0 : hcnt + 10'd1;
         if (hcnt == 10'd799) vcnt <= vcnt == 10'd524 ? 10'd0 : vcnt + 10'd1;
      end
   end

   // frame registers sampled once per frame at the start of vertical blanking so a frame never tears
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         off_latched  <= '0;
         mask_latched <= '0;
      end else if (latch) begin
         off_latched  <= offset_in >= 10'd960 ? offset_in - 10'd960 :
                         offset_in >= 10'd480 ? offset_in - 10'd480 : offset_in;
         mask_latched <= lane_mask;
      end
   end

   // pixel colour: hit line over note bars over lane borders over background, black outside active video
   always_comb begin
      pix_rgb = 12'h000;
      lo      = '0;
      hi      = '0;
      for (int i = 0; i < 4; i++) begin
         lo = 10'(160 * i + 40);
         hi = 10'(160 * i + 119);
         if (hcnt == lo || hcnt == hi) pix_rgb = 12'h444;
         if (ypos < BAR && mask_latched[i] && hcnt >= lo && hcnt <= hi) pix_rgb = LANE_RGB[12*i +: 12];
      end
      if (vcnt >= 10'd440 && vcnt <= 10'd443) pix_rgb = 12'hFFF;
      if (!active) pix_rgb = 12'h000;
   end

   // registered outputs, all one pixel behind the counters that produce them
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hsync      <= 1'b1;
         vsync      <= 1'b1;
         rgb        <= 12'h000;
         frame_tick <= 1'b0;
      end else begin
         frame_tick <= latch;
         if (pix_en) begin
            hsync <= !(hcnt >= 10'd656 && hcnt <= 10'd751);
            vsync <= !(vcnt >= 10'd490 && vcnt <= 10'd491);
            rgb   <= pix_rgb;
         end
      end
   end

endmodule

// File: tb/tb_note_lane_renderer.sv
// tb_note_lane_renderer: scoreboard bench checking raster timing, lane rendering, frame latching and reset
module tb_note_lane_renderer;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [9:0]  offset_in = 10'd0;
   logic [3:0]  lane_mask = 4'd0;
   logic        hsync, vsync, frame_tick;
   logic [11:0] rgb;
   logic        hs4, vs4, ft4;
   logic [11:0] rgb4;

   int          checks = 0;
   int          errors = 0;
   int unsigned pcount = 0;
   bit          div_done = 1'b0;

   typedef struct {
      int unsigned pix;
      logic [14:0] exp;
      string       name;
   } probe_t;

   probe_t sb[$];

   note_lane_renderer #(.CLK_DIV(1), .BAR_H(16)) dut (
      .clk(clk), .reset(reset), .offset_in(offset_in), .lane_mask(lane_mask),
      .hsync(hsync), .vsync(vsync), .rgb(rgb), .frame_tick(frame_tick)
   );

   note_lane_renderer u_div4 (
      .clk(clk), .reset(reset), .offset_in(offset_in), .lane_mask(lane_mask),
      .hsync(hs4), .vsync(vs4), .rgb(rgb4), .frame_tick(ft4)
   );

   always #5 clk = ~clk;

   function automatic int unsigned px(int f, int v, int h);
      return f * 420000 + v * 800 + h;
   endfunction

   // expected output {hsync, vsync, frame_tick, rgb} at frame f, line v, pixel h since reset release
   task automatic expect_px(int f, int v, int h, logic hs, logic vs, logic ft, logic [11:0] c, string name);
      probe_t p;
      int     i;
      p.pix  = px(f, v, h);
      p.exp  = {hs, vs, ft, c};
      p.name = name;
      i = 0;
      while (i < sb.size() && sb[i].pix <= p.pix) i++;
      sb.insert(i, p);
   endtask

   task automatic wait_pix(int unsigned t);
      while (pcount <= t) @(posedge clk);
   endtask

   task automatic check_reset_vals(string name);
      checks++;
      if ({hsync, vsync, frame_tick, rgb} !== {1'b1, 1'b1, 1'b0, 12'h000}) begin
         errors++;
         $display("FAIL %s got hs=%b vs=%b ft=%b rgb=%h want hs=1 vs=1 ft=0 rgb=000",
                  name, hsync, vsync, frame_tick, rgb);
      end
   endtask

   // monitor: one output pixel per negedge after release; compares whenever a probe is due
   initial begin
      forever begin
         @(negedge clk);
         if (!reset) pcount = 0;
         else begin
            while (sb.size() > 0 && sb[0].pix < pcount) begin
               checks++;
               errors++;
               $display("FAIL %s never compared at pix %0d", sb[0].name, sb[0].pix);
               void'(sb.pop_front());
            end
            if (sb.size() > 0 && sb[0].pix == pcount) begin
               probe_t p;
               p = sb.pop_front();
               checks++;
               if ({hsync, vsync, frame_tick, rgb} !== p.exp) begin
                  errors++;
                  $display("FAIL %s pix %0d got hs=%b vs=%b ft=%b rgb=%h want hs=%b vs=%b ft=%b rgb=%h",
                           p.name, p.pix, hsync, vsync, frame_tick, rgb,
                           p.exp[14], p.exp[13], p.exp[12], p.exp[11:0]);
               end
            end
            pcount++;
         end
      end
   end

   // default-parameter instance: hsync period and low width in system clocks
   initial begin
      int   cyc, t0, t1, t2;
      logic prev;
      cyc = 0; t0 = -1; t1 = -1; t2 = -1;
      wait (reset === 1'b1);
      prev = hs4;
      for (int k = 0; k < 20000 && t2 < 0; k++) begin
         @(negedge clk);
         cyc++;
         if (prev && !hs4) begin
            if (t0 < 0) t0 = cyc;
            else        t2 = cyc;
         end
         if (!prev && hs4 && t0 >= 0 && t1 < 0) t1 = cyc;
         prev = hs4;
      end
      checks++;
      if (t0 < 0 || t2 - t0 != 3200) begin
         errors++;
         $display("FAIL div4_hs_period got %0d want 3200", t2 - t0);
      end
      checks++;
      if (t0 < 0 || t1 - t0 != 384) begin
         errors++;
         $display("FAIL div4_hs_low got %0d want 384", t1 - t0);
      end
      div_done = 1'b1;
   end

   initial begin
      repeat (2) @(negedge clk);
      #1;
      check_reset_vals("rst_init");
      expect_px(0, 0, 40,   1, 1, 0, 12'h444, "border_l0");
      expect_px(0, 5, 80,   1, 1, 0, 12'h000, "mask_empty");
      expect_px(0, 3, 599,  1, 1, 0, 12'h444, "border_l3");
      expect_px(0, 3, 600,  1, 1, 0, 12'h000, "past_l3");
      expect_px(0, 0, 655,  1, 1, 0, 12'h000, "hs_pre");
      expect_px(0, 0, 656,  0, 1, 0, 12'h000, "hs_fall");
      expect_px(0, 0, 751,  0, 1, 0, 12'h000, "hs_last");
      expect_px(0, 0, 752,  1, 1, 0, 12'h000, "hs_rise");
      expect_px(0, 300, 700, 0, 1, 0, 12'h000, "pre_reset");
      reset = 1'b1;
      wait_pix(px(0, 300, 701));
      @(negedge clk);
      #1;
      reset = 1'b0;
      #1;
      check_reset_vals("rst_async");
      repeat (3) @(posedge clk);
      @(negedge clk);
      #1;
      check_reset_vals("rst_hold");
      offset_in = 10'd470;
      lane_mask = 4'b0001;
      expect_px(0, 0, 40,    1, 1, 0, 12'h444, "restart_border");
      expect_px(0, 0, 656,   0, 1, 0, 12'h000, "restart_hs");
      expect_px(0, 10, 80,   1, 1, 0, 12'h000, "no_early_latch");
      expect_px(0, 440, 100, 1, 1, 0, 12'hFFF, "hit_line");
      expect_px(0, 440, 640, 1, 1, 0, 12'h000, "hit_inactive_x");
      expect_px(0, 443, 0,   1, 1, 0, 12'hFFF, "hit_end");
      expect_px(0, 444, 0,   1, 1, 0, 12'h000, "hit_after");
      expect_px(0, 479, 799, 1, 1, 0, 12'h000, "pre_tick");
      expect_px(0, 480, 0,   1, 1, 1, 12'h000, "tick");
      expect_px(0, 480, 1,   1, 1, 0, 12'h000, "tick_end");
      expect_px(0, 489, 0,   1, 1, 0, 12'h000, "vs_pre");
      expect_px(0, 490, 0,   1, 0, 0, 12'h000, "vs_fall");
      expect_px(0, 491, 799, 1, 0, 0, 12'h000, "vs_last");
      expect_px(0, 492, 0,   1, 1, 0, 12'h000, "vs_rise");
      expect_px(1, 9, 80,    1, 1, 0, 12'h000, "off470_above");
      expect_px(1, 10, 80,   1, 1, 0, 12'hF00, "off470_top");
      expect_px(1, 25, 80,   1, 1, 0, 12'hF00, "off470_bottom");
      expect_px(1, 26, 80,   1, 1, 0, 12'h000, "off470_below");
      expect_px(1, 10, 40,   1, 1, 0, 12'hF00, "bar_left_edge");
      expect_px(1, 10, 119,  1, 1, 0, 12'hF00, "bar_right_edge");
      expect_px(1, 10, 39,   1, 1, 0, 12'h000, "bar_left_out");
      expect_px(1, 10, 120,  1, 1, 0, 12'h000, "bar_right_out");
      expect_px(1, 10, 200,  1, 1, 0, 12'h444, "l1_border_masked");
      expect_px(1, 10, 201,  1, 1, 0, 12'h000, "l1_masked");
      expect_px(1, 442, 80,  1, 1, 0, 12'hFFF, "hit_f1");
      expect_px(1, 445, 80,  1, 1, 0, 12'h000, "midframe_off");
      expect_px(1, 450, 201, 1, 1, 0, 12'h000, "midframe_mask");
      expect_px(1, 480, 0,   1, 1, 1, 12'h000, "tick2");
      expect_px(2, 0, 80,    1, 1, 0, 12'h000, "off1000_top");
      expect_px(2, 439, 80,  1, 1, 0, 12'h000, "off1000_above");
      expect_px(2, 440, 80,  1, 1, 0, 12'hFFF, "hit_over_bar");
      expect_px(2, 443, 360, 1, 1, 0, 12'hFFF, "hit_over_bar2");
      expect_px(2, 444, 80,  1, 1, 0, 12'hF00, "lane0_colour");
      expect_px(2, 444, 200, 1, 1, 0, 12'h0F0, "bar_over_border");
      expect_px(2, 444, 240, 1, 1, 0, 12'h0F0, "lane1_colour");
      expect_px(2, 444, 599, 1, 1, 0, 12'hFF0, "lane3_edge");
      expect_px(2, 444, 600, 1, 1, 0, 12'h000, "lane3_out");
      expect_px(2, 450, 400, 1, 1, 0, 12'h00F, "lane2_colour");
      expect_px(2, 455, 560, 1, 1, 0, 12'hFF0, "lane3_colour");
      expect_px(2, 456, 560, 1, 1, 0, 12'h000, "off1000_below");
      reset = 1'b1;
      wait_pix(px(1, 200, 0));
      @(negedge clk);
      #1;
      offset_in = 10'd1000;
      lane_mask = 4'b1111;
      wait_pix(px(2, 456, 600));
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL sb_drain got %0d pending want 0", sb.size());
      end
      wait (div_done);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
